// File: rtl/z16_boot_loader_if.sv
// Byte-stream, restart and instruction-memory write signals between a
// stream source / memory (master) and the Z16 boot loader (slave).
interface z16_boot_loader_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        i_restart;
    logic        o_imem_we;
    logic [15:0] o_imem_addr;
    logic [15:0] o_imem_wdata;
    logic        o_cpu_rst;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_rx_valid, i_rx_data, i_restart,
        input  o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata,
               o_cpu_rst, o_busy, o_done, o_err
    );

    modport slave (
        input  i_rx_valid, i_rx_data, i_restart,
        output o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata,
               o_cpu_rst, o_busy, o_done, o_err
    );
endinterface

// File: rtl/z16_boot_loader.sv
// Length-prefixed byte stream loader: packs bytes into 16-bit words, writes them to
// instruction memory, and releases the CPU reset only after the XOR checksum matches.
module z16_boot_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    z16_boot_loader_if.slave   bus
);
    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_reg, state_next;
    logic [7:0]  len_lo_reg;
    logic [15:0] len_reg;
    logic [15:0] k_reg;
    logic [7:0]  low_reg;
    logic [7:0]  xor_reg;

    logic        rx_ready_reg;
    logic        imem_we_reg;
    logic [15:0] imem_addr_reg;
    logic [15:0] imem_wdata_reg;
    logic        cpu_rst_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;

    logic        accept;
    logic [15:0] len_full;

    assign accept   = bus.i_rx_valid && rx_ready_reg;
    assign len_full = {bus.i_rx_data, len_lo_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LEN_LO:  if (accept) state_next = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_LEN) state_next = ERR;
                    else if (len_full == 16'd0)     state_next = CSUM;
                    else                            state_next = DATA_LO;
                end
            end
            DATA_LO: if (accept) state_next = DATA_HI;
            DATA_HI: begin
                if (accept) state_next = (k_reg + 16'd1 == len_reg) ? CSUM : DATA_LO;
            end
            CSUM: begin
                if (accept) state_next = (bus.i_rx_data == xor_reg) ? DONE : ERR;
            end
            DONE, ERR: if (bus.i_restart) state_next = LEN_LO;
            default: state_next = LEN_LO;
        endcase
    end

    // Status outputs are derived from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= LEN_LO;
            len_lo_reg     <= 8'h00;
            len_reg        <= 16'h0000;
            k_reg          <= 16'h0000;
            low_reg        <= 8'h00;
            xor_reg        <= 8'h00;
            rx_ready_reg   <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= 16'h0000;
            imem_wdata_reg <= 16'h0000;
            cpu_rst_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rx_ready_reg <= (state_next inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM});
            busy_reg     <= (state_next inside {LEN_HI, DATA_LO, DATA_HI, CSUM});
            done_reg     <= (state_next == DONE);
            err_reg      <= (state_next == ERR);
            cpu_rst_reg  <= (state_next != DONE);
            imem_we_reg  <= 1'b0;
            case (state_reg)
                LEN_LO: if (accept) len_lo_reg <= bus.i_rx_data;
                LEN_HI: begin
                    if (accept) begin
                        len_reg <= len_full;
                        k_reg   <= 16'h0000;
                        xor_reg <= 8'h00;
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        low_reg <= bus.i_rx_data;
                        xor_reg <= xor_reg ^ bus.i_rx_data;
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        xor_reg        <= xor_reg ^ bus.i_rx_data;
                        imem_we_reg    <= 1'b1;
                        imem_addr_reg  <= {k_reg[14:0], 1'b0};
                        imem_wdata_reg <= {bus.i_rx_data, low_reg};
                        k_reg          <= k_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_rx_ready   = rx_ready_reg;
    assign bus.o_imem_we    = imem_we_reg;
    assign bus.o_imem_addr  = imem_addr_reg;
    assign bus.o_imem_wdata = imem_wdata_reg;
    assign bus.o_cpu_rst    = cpu_rst_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_done       = done_reg;
    assign bus.o_err        = err_reg;
endmodule

// File: tb/tb_z16_boot_loader.sv
// Directed bench for z16_boot_loader: stimulus pushes expected writes/outcomes
// into queues that a negedge monitor pops whenever the DUT strobes or finishes.
module tb_z16_boot_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    z16_boot_loader_if bus();

    z16_boot_loader #(.MAX_WORDS(1024)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;
    logic [31:0] wr_q[$];
    bit          out_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: compares every write strobe and every done/err rising edge.
    logic        prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    logic [31:0] exp_wr;
    bit          exp_out;
    always @(negedge clk) begin
        if (bus.o_imem_we === 1'b1) begin
            $display("write addr=0x%04h data=0x%04h", bus.o_imem_addr, bus.o_imem_wdata);
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (wr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr 0x%04h data 0x%04h, expected no write",
                         bus.o_imem_addr, bus.o_imem_wdata);
            end else begin
                exp_wr = wr_q.pop_front();
                check("imem_write", {bus.o_imem_addr, bus.o_imem_wdata}, exp_wr);
            end
        end
        if (bus.o_done === 1'b1 && prev_done === 1'b0) begin
            $display("outcome done");
            if (out_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done, expected no outcome");
            end else begin
                exp_out = out_q.pop_front();
                check("outcome_is_err", 32'd0, {31'd0, exp_out});
                check("cpu_rst_on_done", {31'd0, bus.o_cpu_rst}, 32'd0);
            end
        end
        if (bus.o_err === 1'b1 && prev_err === 1'b0) begin
            $display("outcome err");
            if (out_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_err: got err, expected no outcome");
            end else begin
                exp_out = out_q.pop_front();
                check("outcome_is_err", 32'd1, {31'd0, exp_out});
                check("cpu_rst_on_err", {31'd0, bus.o_cpu_rst}, 32'd1);
            end
        end
        prev_we   <= bus.o_imem_we;
        prev_done <= bus.o_done;
        prev_err  <= bus.o_err;
    end

    // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        while (bus.o_rx_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_timeout: got rx_ready 0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic bubbles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart_pulse();
        bus.i_restart = 1'b1;
        @(posedge clk);
        #1;
        bus.i_restart = 1'b0;
        check("restart_err",     {31'd0, bus.o_err},      32'd0);
        check("restart_done",    {31'd0, bus.o_done},     32'd0);
        check("restart_ready",   {31'd0, bus.o_rx_ready}, 32'd1);
        check("restart_cpu_rst", {31'd0, bus.o_cpu_rst},  32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0] good[7];
    initial begin
        good[0] = 8'h02; good[1] = 8'h00; good[2] = 8'h34; good[3] = 8'h12;
        good[4] = 8'h78; good[5] = 8'h56; good[6] = 8'h08;

        // Reset with a byte offered: nothing may be accepted.
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'h05;
        bus.i_restart  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", {31'd0, bus.o_rx_ready}, 32'd0);
        check("rst_we",       {31'd0, bus.o_imem_we},  32'd0);
        check("rst_addr_data", {bus.o_imem_addr, bus.o_imem_wdata}, 32'd0);
        check("rst_flags", {28'd0, bus.o_cpu_rst, bus.o_busy, bus.o_done, bus.o_err}, 32'h8);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        check("ready_after_rst", {31'd0, bus.o_rx_ready}, 32'd1);
        bubbles(1);
        check("no_xfer_in_rst", {31'd0, bus.o_busy}, 32'd0);

        // Good load, back-to-back.
        wr_q.push_back(32'h0000_1234);
        wr_q.push_back(32'h0002_5678);
        out_q.push_back(1'b0);
        send(good[0]);
        check("busy_after_len_lo", {31'd0, bus.o_busy}, 32'd1);
        send(good[1]); send(good[2]); send(good[3]);
        check("write_latency", {31'd0, bus.o_imem_we}, 32'd1);
        send(good[4]); send(good[5]); send(good[6]);
        check("good_done",    {31'd0, bus.o_done},     32'd1);
        check("good_cpu_rst", {31'd0, bus.o_cpu_rst},  32'd0);
        check("good_ready",   {31'd0, bus.o_rx_ready}, 32'd0);
        check("good_busy",    {31'd0, bus.o_busy},     32'd0);
        bubbles(2);
        restart_pulse();

        // Bad checksum.
        wr_q.push_back(32'h0000_1234);
        wr_q.push_back(32'h0002_5678);
        out_q.push_back(1'b1);
        for (int i = 0; i < 6; i++) send(good[i]);
        send(8'h09);
        check("badsum_err",     {31'd0, bus.o_err},     32'd1);
        check("badsum_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
        bubbles(2);
        restart_pulse();

        // Empty image, good and bad checksum.
        out_q.push_back(1'b0);
        send(8'h00); send(8'h00); send(8'h00);
        check("empty_done", {31'd0, bus.o_done}, 32'd1);
        bubbles(1);
        restart_pulse();
        out_q.push_back(1'b1);
        send(8'h00); send(8'h00); send(8'h01);
        check("empty_err", {31'd0, bus.o_err}, 32'd1);
        bubbles(1);
        restart_pulse();

        // Overflow: N = 0x0401 > 1024.
        out_q.push_back(1'b1);
        send(8'h01); send(8'h04);
        check("overflow_err", {31'd0, bus.o_err}, 32'd1);
        bubbles(3);
        restart_pulse();

        // Good load with random bubbles.
        wr_q.push_back(32'h0000_1234);
        wr_q.push_back(32'h0002_5678);
        out_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) begin
            bubbles(int'($urandom_range(0, 3)));
            send(good[i]);
        end
        check("gaps_done", {31'd0, bus.o_done}, 32'd1);
        bubbles(1);
        restart_pulse();

        // Reset after the first word: second word must never be written.
        wr_q.push_back(32'h0000_1234);
        for (int i = 0; i < 5; i++) send(good[i]);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
        check("midrst_busy",    {31'd0, bus.o_busy},    32'd0);
        check("midrst_we",      {31'd0, bus.o_imem_we}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", {31'd0, bus.o_rx_ready}, 32'd1);
        // A fresh full stream proves the loader is back at LEN_LO.
        wr_q.push_back(32'h0000_1234);
        wr_q.push_back(32'h0002_5678);
        out_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) send(good[i]);
        check("midrst_reload_done", {31'd0, bus.o_done}, 32'd1);
        bubbles(3);

        check("writes_drained",   wr_q.size(),  32'd0);
        check("outcomes_drained", out_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/z16_boot_loader.md
# z16_boot_loader

Serial-stream program loader for the Z16 core: accepts a length-prefixed byte stream over a valid/ready handshake and packs it into 16-bit little-endian words. It writes those words into instruction memory at byte addresses 0x0000, 0x0002, and so on, matching the PC's 2-byte stride. It holds the CPU in reset until the whole image and its XOR checksum are verified, then releases it. It is the write-side counterpart of the CPU's instruction fetch path.

## Interface

- MAX_WORDS, 1024: largest accepted image in words; must be ≤ 32768.
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_rx_valid  in  1  byte on i_rx_data is valid
- i_rx_data  in  8  stream byte
- o_rx_ready  out  1  loader accepts a byte; a transfer occurs when i_rx_valid && o_rx_ready at a rising edge
- i_restart  in  1  single-cycle re-arm request; honoured only in DONE or ERR
- o_imem_we  out  1  instruction memory write strobe, one cycle per word
- o_imem_addr  out  16  byte address of the word being written
- o_imem_wdata  out  16  word data {high byte, low byte}
- o_cpu_rst  out  1  active-high reset to the CPU (drives its i_rst)
- o_busy  out  1  load in progress
- o_done  out  1  image loaded and checksum matched
- o_err  out  1  load failed (length overflow or checksum mismatch)

## Operation

- Stream format: LEN_LO, LEN_HI (N = word count, little-endian), then 2N payload bytes as low byte, high byte per word, then CSUM. CSUM is the XOR of all payload bytes only.
- States: LEN_LO → LEN_HI → DATA_LO ⇄ DATA_HI → CSUM → DONE | ERR. Each arrow is taken on one accepted byte.
- LEN_HI accepted:
  - N > MAX_WORDS: go to ERR.
  - N == 0: go to CSUM (expected CSUM is 0x00).
  - Otherwise: go to DATA_LO, and clear the word index k and the running XOR.
- DATA_LO accepted: latch the low byte and fold it into the XOR.
- DATA_HI accepted:
  - Fold the byte into the XOR.
  - On the next cycle: o_imem_we=1, o_imem_addr={k[14:0],1'b0}, o_imem_wdata={byte, latched low}.
  - Increment k.
  - If k+1 == N, go to CSUM; else go to DATA_LO.
- CSUM accepted:
  - Byte equals the XOR: go to DONE.
  - Otherwise: go to ERR.
- DONE: o_done=1, o_cpu_rst=0, o_busy=0, o_rx_ready=0.
- ERR: o_err=1, o_cpu_rst=1, o_busy=0, o_rx_ready=0.
- i_restart in DONE or ERR: go to LEN_LO next cycle. o_cpu_rst=1, o_done=0, o_err=0, o_rx_ready=1.
- i_restart in any other state: ignored.
- o_rx_ready is 1 in LEN_LO through CSUM, with no back-pressure during writes.
- o_busy rises on the cycle after the LEN_LO byte is accepted. It stays high until DONE or ERR is entered.
- Bubbles (i_rx_valid=0) are allowed in any state. The state machine holds, and no write is issued.
- o_imem_addr and o_imem_wdata hold their last written values between strobes.

## Timing

- All outputs are registered.
- Reset values:
  - o_rx_ready=0, o_imem_we=0, o_imem_addr=0x0000, o_imem_wdata=0x0000
  - o_cpu_rst=1, o_busy=0, o_done=0, o_err=0
  - state=LEN_LO
- o_rx_ready=1 on the first cycle after i_rst_n returns high.
- Write latency: o_imem_we is asserted exactly 1 cycle after the DATA_HI byte is accepted.
- The last write always completes before CSUM can be accepted.
- o_done and o_err rise, and o_cpu_rst falls in the DONE case, 1 cycle after the CSUM byte is accepted.
- ERR on overflow: o_err rises 1 cycle after LEN_HI is accepted, and no write occurs.
- Minimum load time: 2N+3 consecutive cycles of bytes; o_cpu_rst falls on cycle 2N+4.
- Reset mid-load: state returns to LEN_LO, o_cpu_rst=1, and any strobe in flight is cancelled. Words already written stay in memory; there is no rollback.
- i_restart and i_rst_n low in the same cycle: reset wins.

## Test plan

- Reset: hold i_rst_n=0 with i_rx_valid=1 → all outputs at reset values and no transfer. After release, o_rx_ready=1 on the next cycle.
- Good load: bytes 02 00 34 12 78 56 08 back-to-back → writes 0x1234@0x0000 and 0x5678@0x0002, each a one-cycle strobe. Then o_done=1, o_cpu_rst=0, o_rx_ready=0.
- Bad checksum: same stream ending in 09 → the same two writes, then o_err=1 with o_cpu_rst held at 1. An i_restart pulse → o_err=0 and o_rx_ready=1 next cycle.
- Empty image: 00 00 00 → no o_imem_we, o_done=1. Stream 00 00 01 → o_err=1.
- Overflow: with MAX_WORDS=1024, bytes 01 04 → o_err=1 one cycle after LEN_HI is accepted, and no writes.
- Gaps and mid-load reset: good stream with random valid=0 bubbles → identical writes and o_done. Separately, pull i_rst_n low after the first word → o_cpu_rst=1, o_busy=0, state LEN_LO, and no second write.
